// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: gates camera luma to whole frames, appends a zero flush line, latches threshold per frame
module sobel_frame_ctrl #(
    parameter int H_PIX       = 640,
    parameter int V_LINE      = 480,
    parameter int FLUSH_LINES = 1
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  cfg_en,
    input  logic [7:0]                            cfg_thresh,
    input  logic                                  cam_vsync,
    input  logic                                  pix_valid,
    input  logic [7:0]                            pix_Y,
    output logic                                  sobel_wr_en,
    output logic [7:0]                            sobel_img_Y,
    output logic [7:0]                            sobel_thresh,
    output logic [$clog2(H_PIX)-1:0]              col_cnt,
    output logic [$clog2(V_LINE+FLUSH_LINES)-1:0] row_cnt,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  overrun_err
);
    localparam int CW = $clog2(H_PIX);
    localparam int RW = $clog2(V_LINE + FLUSH_LINES);
    localparam logic [CW-1:0] COL_LAST = CW'(H_PIX - 1);
    localparam logic [RW-1:0] ROW_PIX_LAST = RW'(V_LINE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_LINE + FLUSH_LINES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_VS, ACTIVE, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic          vs_q;
    logic          wr_q, wr_d;
    logic [7:0]    y_q, y_d;
    logic [7:0]    thr_q, thr_d;
    logic [CW-1:0] col_q, col_d, pcol_q, pcol_d;
    logic [RW-1:0] row_q, row_d, prow_q, prow_d;
    logic          ph_q, ph_d;
    logic          err_q, err_d;
    logic          vs_rise, start, fwd;
    logic [7:0]    fwd_y;

    assign vs_rise      = cam_vsync & ~vs_q;
    assign sobel_wr_en  = wr_q;
    assign sobel_img_Y  = y_q;
    assign sobel_thresh = thr_q;
    assign col_cnt      = col_q;
    assign row_cnt      = row_q;
    assign busy         = (state_q == ACTIVE) || (state_q == FLUSH);
    assign frame_done   = (state_q == DONE);
    assign overrun_err  = err_q;

    // next-state: pcol/prow point at the next pixel slot, col/row describe the last forwarded one
    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        col_d   = col_q;
        row_d   = row_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        ph_d    = ph_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        y_d     = y_q;
        start   = 1'b0;
        fwd     = 1'b0;
        fwd_y   = 8'd0;
        case (state_q)
            IDLE:    state_d = cfg_en ? WAIT_VS : IDLE;
            WAIT_VS: begin
                start   = vs_rise;
                state_d = cfg_en ? WAIT_VS : IDLE;
            end
            ACTIVE: begin
                start = vs_rise;
                err_d = err_q | vs_rise;
                fwd   = pix_valid & ~vs_rise;
                fwd_y = pix_Y;
                if (fwd && pcol_q == COL_LAST && prow_q == ROW_PIX_LAST) state_d = FLUSH;
            end
            FLUSH: begin
                start = vs_rise;
                err_d = err_q | vs_rise;
                fwd   = ~ph_q & ~vs_rise;
                ph_d  = ~ph_q;
                if (ph_q && col_q == COL_LAST && row_q == ROW_LAST) state_d = DONE;
            end
            DONE:    state_d = cfg_en ? WAIT_VS : IDLE;
            default: state_d = IDLE;
        endcase
        if (fwd) begin
            wr_d   = 1'b1;
            y_d    = fwd_y;
            col_d  = pcol_q;
            row_d  = prow_q;
            pcol_d = (pcol_q == COL_LAST) ? '0 : pcol_q + CW'(1);
            prow_d = (pcol_q == COL_LAST) ? prow_q + RW'(1) : prow_q;
        end
        if (start) begin
            state_d = ACTIVE;
            thr_d   = cfg_thresh;
            col_d   = '0;
            row_d   = '0;
            pcol_d  = '0;
            prow_d  = '0;
            ph_d    = 1'b0;
        end
        if (state_d == IDLE && state_q != IDLE) err_d = 1'b0;
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            wr_q    <= 1'b0;
            y_q     <= 8'd0;
            thr_q   <= 8'd0;
            col_q   <= '0;
            row_q   <= '0;
            pcol_q  <= '0;
            prow_q  <= '0;
            ph_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= cam_vsync;
            wr_q    <= wr_d;
            y_q     <= y_d;
            thr_q   <= thr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
            ph_q    <= ph_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed self-checking bench for sobel_frame_ctrl on an 8x4 frame
module tb_sobel_frame_ctrl;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] cfg_thresh = 8'd0;
    logic [7:0] pix_Y = 8'd0;
    logic       sobel_wr_en;
    logic [7:0] sobel_img_Y;
    logic [7:0] sobel_thresh;
    logic [2:0] col_cnt;
    logic [2:0] row_cnt;
    logic       busy;
    logic       frame_done;
    logic       overrun_err;

    int nvec = 0;
    int nmis = 0;
    int cyc_n = 0;
    int nstr, nzero, nfd, last_str, done_at, max_row, first_y, done_thr, done_col, done_row;
    bit got_first;

    sobel_frame_ctrl #(.H_PIX(8), .V_LINE(4), .FLUSH_LINES(1)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .cfg_en(cfg_en),
        .cfg_thresh(cfg_thresh),
        .cam_vsync(cam_vsync),
        .pix_valid(pix_valid),
        .pix_Y(pix_Y),
        .sobel_wr_en(sobel_wr_en),
        .sobel_img_Y(sobel_img_Y),
        .sobel_thresh(sobel_thresh),
        .col_cnt(col_cnt),
        .row_cnt(row_cnt),
        .busy(busy),
        .frame_done(frame_done),
        .overrun_err(overrun_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        nstr = 0; nzero = 0; nfd = 0; last_str = 0; done_at = 0; max_row = 0;
        first_y = 0; done_thr = 0; done_col = 0; done_row = 0; got_first = 1'b0;
    endtask

    task automatic cyc();
        @(negedge sys_clk);
        cyc_n++;
        if (sobel_wr_en) begin
            nstr++;
            last_str = cyc_n;
            if (sobel_img_Y == 8'd0) nzero++;
            if (!got_first) begin
                got_first = 1'b1;
                first_y = int'(sobel_img_Y);
            end
            if (int'(row_cnt) > max_row) max_row = int'(row_cnt);
        end
        if (frame_done) begin
            nfd++;
            done_at = cyc_n;
            done_col = int'(col_cnt);
            done_row = int'(row_cnt);
            done_thr = int'(sobel_thresh);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic vsync();
        cam_vsync = 1'b1;
        cyc();
        cam_vsync = 1'b0;
        cyc();
    endtask

    task automatic pixels(input int n, input int y0);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_Y = 8'(y0 + i);
            cyc();
            pix_valid = 1'b0;
            cyc();
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_wr"}, int'(sobel_wr_en), 0);
        chk({tag, "_y"}, int'(sobel_img_Y), 0);
        chk({tag, "_thr"}, int'(sobel_thresh), 0);
        chk({tag, "_col"}, int'(col_cnt), 0);
        chk({tag, "_row"}, int'(row_cnt), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_err"}, int'(overrun_err), 0);
    endtask

    initial begin
        clr();
        idle(3);
        all_zero("rst");
        sys_rst_n = 1'b1;
        cfg_en = 1'b1;
        cfg_thresh = 8'h40;
        cyc();
        chk("wait_busy", int'(busy), 0);
        vsync();
        chk("start_busy", int'(busy), 1);
        chk("start_thr", int'(sobel_thresh), 8'h40);

        clr();
        pixels(16, 1);
        cfg_thresh = 8'h80;
        chk("thr_mid", int'(sobel_thresh), 8'h40);
        pixels(16, 17);
        idle(24);
        chk("full_strobes", nstr, 40);
        chk("full_zero", nzero, 8);
        chk("full_first_y", first_y, 1);
        chk("full_done_cnt", nfd, 1);
        chk("full_done_lat", done_at - last_str, 1);
        chk("full_done_col", done_col, 7);
        chk("full_done_row", done_row, 4);
        chk("full_max_row", max_row, 4);
        chk("full_thr", done_thr, 8'h40);
        chk("full_err", int'(overrun_err), 0);
        chk("full_busy", int'(busy), 0);
        vsync();
        chk("thr_next", int'(sobel_thresh), 8'h80);

        clr();
        pixels(13, 1);
        vsync();
        chk("early_err", int'(overrun_err), 1);
        chk("early_col", int'(col_cnt), 0);
        chk("early_row", int'(row_cnt), 0);
        chk("early_busy", int'(busy), 1);
        chk("early_strobes", nstr, 13);
        chk("early_no_done", nfd, 0);
        clr();
        pixels(32, 1);
        idle(24);
        chk("after_done", nfd, 1);
        chk("after_strobes", nstr, 40);
        chk("after_err", int'(overrun_err), 1);
        cfg_en = 1'b0;
        cyc();
        chk("err_clr", int'(overrun_err), 0);

        cfg_en = 1'b1;
        cyc();
        vsync();
        clr();
        pixels(10, 1);
        cfg_en = 1'b0;
        pixels(22, 11);
        idle(24);
        chk("dis_done", nfd, 1);
        chk("dis_strobes", nstr, 40);
        chk("dis_busy", int'(busy), 0);
        vsync();
        chk("idle_no_vs", int'(busy), 0);

        cfg_en = 1'b1;
        cfg_thresh = 8'h33;
        cyc();
        vsync();
        clr();
        pixels(32, 1);
        idle(4);
        chk("flush_busy", int'(busy), 1);
        chk("flush_no_done", nfd, 0);
        sys_rst_n = 1'b0;
        cyc();
        sys_rst_n = 1'b1;
        all_zero("mid_rst");

        clr();
        pixels(5, 32);
        chk("pre_vs_strobes", nstr, 0);
        cam_vsync = 1'b1;
        pix_valid = 1'b1;
        pix_Y = 8'hAA;
        cyc();
        cam_vsync = 1'b0;
        pix_valid = 1'b0;
        cyc();
        chk("vs_pix_drop", nstr, 0);
        pixels(1, 8'h55);
        chk("post_vs_strobes", nstr, 1);
        chk("post_vs_y", first_y, 8'h55);
        chk("post_vs_col", int'(col_cnt), 0);
        chk("post_vs_row", int'(row_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame sequencer placed between the camera Y-channel capture and `sobel_isp`. It gates the pixel stream to whole frames delimited by `cam_vsync`, and tracks column and row position. After the last camera pixel it appends one zero-filled flush line so the 3x3 window generator emits the final image row. It also latches the Sobel threshold only at frame boundaries, and reports frame completion and sync errors to the system controller.

## Interface
- `H_PIX`, 640, active pixels per line
- `V_LINE`, 480, active lines per frame
- `FLUSH_LINES`, 1, zero lines appended after the last frame line
- `sys_clk`  in  1  system clock; all logic on its rising edge
- `sys_rst_n`  in  1  synchronous active-low reset
- `cfg_en`  in  1  level; 1 = sequencer enabled
- `cfg_thresh`  in  8  Sobel threshold request
- `cam_vsync`  in  1  frame sync, active high; a frame starts on its rising edge
- `pix_valid`  in  1  camera pixel strobe (at most every other cycle)
- `pix_Y`  in  8  camera luma
- `sobel_wr_en`  out  1  pixel strobe to `sobel_isp`
- `sobel_img_Y`  out  8  luma to `sobel_isp`
- `sobel_thresh`  out  8  frame-stable threshold
- `col_cnt`  out  $clog2(H_PIX)  column of the last forwarded pixel
- `row_cnt`  out  $clog2(V_LINE+FLUSH_LINES)  row of the last forwarded pixel
- `busy`  out  1  high in ACTIVE or FLUSH
- `frame_done`  out  1  one-cycle pulse at frame completion
- `overrun_err`  out  1  sticky sync-error flag

## Operation
- Reset (`sys_rst_n`=0 at a clock edge) values:
  - state = IDLE
  - all outputs 0, `sobel_thresh` = 0
  - `vsync_d` register = 0
- `vsync_rise` = `cam_vsync` & ~`vsync_d`; `vsync_d` samples `cam_vsync` every cycle.
- **IDLE:** outputs held. `cfg_en`=1 → WAIT_VS.
- **WAIT_VS:**
  - `pix_valid` is ignored.
  - On `vsync_rise`: `sobel_thresh` <= `cfg_thresh`; col/row counters <= 0 (first-pixel pointer) → ACTIVE.
  - `cfg_en`=0 → IDLE. `vsync_rise` takes priority if both occur in the same cycle.
- **ACTIVE:**
  - Each `pix_valid`: forward `pix_Y` with `sobel_wr_en`=1.
  - `col_cnt` wraps H_PIX-1 → 0 and increments `row_cnt` at the wrap.
  - Accepting pixel (H_PIX-1, V_LINE-1) → FLUSH.
- **FLUSH:**
  - Emits FLUSH_LINES×H_PIX pixels of value 0, one every second cycle, starting the first cycle after entry.
  - `pix_valid` is ignored.
  - After the last flush pixel → DONE.
- **DONE (one cycle):**
  - `frame_done`=1.
  - Next state: WAIT_VS if `cfg_en`=1, else IDLE.
- `vsync_rise` in ACTIVE or FLUSH:
  - Current frame is aborted and `overrun_err` <= 1.
  - Counters reset, threshold re-latched; state → ACTIVE (new frame starts).
  - `frame_done` is not pulsed for the aborted frame.
- `cfg_en`=0 in ACTIVE or FLUSH:
  - The frame completes normally, then the FSM goes to IDLE.
- `overrun_err` clears only on entry to IDLE or on reset.
- `cfg_thresh` changes outside WAIT_VS do not affect `sobel_thresh`.
- Counters never exceed H_PIX-1 and V_LINE+FLUSH_LINES-1. Extra `pix_valid` pulses in FLUSH or DONE are dropped.

## Timing
- `sobel_wr_en` and `sobel_img_Y` are registered: one cycle of latency from `pix_valid`/`pix_Y`.
  - `sobel_wr_en` is 0 whenever no pixel is forwarded.
  - `sobel_img_Y` holds its last value while `sobel_wr_en` is 0.
- A `pix_valid` in the same cycle as an accepted `vsync_rise` is dropped; the first frame pixel is the next `pix_valid`.
- `busy` and `sobel_thresh` update on the clock edge that sees the triggering condition.
- `col_cnt`/`row_cnt` update together with the `sobel_wr_en` they describe.
- Flush strobes follow the pattern 1,0,1,0 with no gaps between lines.
- `frame_done` asserts the cycle after the final flush strobe.
- Synchronous reset mid-frame: all outputs are 0 after that edge, and no further strobes occur until a new `vsync_rise` in WAIT_VS.

## Test plan
All scenarios use H_PIX=8, V_LINE=4, FLUSH_LINES=1, with pixels on alternate cycles and an incrementing `pix_Y`.

- **Full frame:** `cfg_en`=1, vsync pulse, 32 pixels → exactly 32 forwarded plus 8 zero strobes. `row_cnt` ends at 4, `col_cnt` at 7, one `frame_done`, `overrun_err`=0.
- **Threshold latch:** `cfg_thresh`=0x40 at the vsync edge, changed to 0x80 mid-frame → `sobel_thresh` stays 0x40 for the whole frame, then 0x80 after the next vsync.
- **Early vsync:** second vsync after 13 pixels → `overrun_err`=1, counters restart at 0, no `frame_done`. The next full frame completes and `overrun_err` stays 1 until `cfg_en`=0.
- **Disable mid-frame:** `cfg_en`=0 at pixel 10 → the frame and its flush complete, `frame_done` pulses, FSM goes to IDLE, `busy`=0.
- **Reset mid-flush:** `sys_rst_n`=0 for one edge during FLUSH → all outputs 0 next cycle. Pixels without a vsync produce no strobes.
- **Pixels before vsync:** 5 pixels, then vsync → 0 strobes before the vsync; the first strobe carries the first post-vsync `pix_Y`.
